// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: round-robin owner of the single memory write port, shared by NUM_CLIENTS writers.
// Latency: one cycle from request to grant; line data, control and per-line ack pass through combinationally.
// Backpressure: the granted client stalls on mem_ack; losing clients hold their request until they are served.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cl_mem_*, cl_last   - per-client write request bundles (request, addr, size, line, last-valid, last)
//   cl_mem_ack          - per-client line acknowledge, only ever asserted for the granted client
//   mem_*, last         - memory-side write port, a mux of the granted client's bundle
//   mem_ack             - memory accepted the current line
//   grant_id, busy      - index of the granted client and "transaction in progress"
module mem_write_arbiter #(
    parameter int NUM_CLIENTS       = 4,
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    localparam int LV_W   = $clog2(NUM_WORDS_IN_LINE),
    localparam int LINE_W = NUM_WORDS_IN_LINE * WORD_WIDTH,
    localparam int ID_W   = $clog2(NUM_CLIENTS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_CLIENTS-1:0]                 cl_mem_req,
    input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_mem_start_addr,
    input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_mem_size_bytes,
    input  logic [NUM_CLIENTS-1:0][LINE_W-1:0]     cl_mem_data,
    input  logic [NUM_CLIENTS-1:0][LV_W-1:0]       cl_mem_last_valid,
    input  logic [NUM_CLIENTS-1:0]                 cl_last,
    output logic [NUM_CLIENTS-1:0]                 cl_mem_ack,
    output logic                                   mem_req,
    output logic [ADDR_WIDTH-1:0]                  mem_start_addr,
    output logic [ADDR_WIDTH-1:0]                  mem_size_bytes,
    output logic [LINE_W-1:0]                      mem_data,
    output logic [LV_W-1:0]                        mem_last_valid,
    output logic                                   last,
    input  logic                                   mem_ack,
    output logic [ID_W-1:0]                        grant_id,
    output logic                                   busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;

    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   next_ptr;
    logic              release_w;

    // Pick the first requester at or after rr_ptr. Walking offsets from the
    // far end down to zero lets the smallest offset overwrite the others.
    always_comb begin
        int sum;
        sum      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
            sum = int'(rr_ptr_q) + off;
            if (sum >= NUM_CLIENTS) begin
                sum = sum - NUM_CLIENTS;
            end
            if (cl_mem_req[ID_W'(sum)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(sum);
            end
        end
    end

    // The client just served drops to lowest priority.
    assign next_ptr = (grant_id_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id_q + 1'b1;

    // A transaction ends on the ack of its last line, or when the owner abandons its request.
    assign release_w = !cl_mem_req[grant_id_q] || (mem_ack && cl_last[grant_id_q]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_id;
                end
            end
            ST_GRANT: begin
                if (release_w) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: everything is zero outside a grant, so an asynchronous
    // reset silences the memory port immediately.
    always_comb begin
        cl_mem_ack     = '0;
        mem_req        = 1'b0;
        mem_start_addr = '0;
        mem_size_bytes = '0;
        mem_data       = '0;
        mem_last_valid = '0;
        last           = 1'b0;
        busy           = 1'b0;
        if (state_q == ST_GRANT) begin
            busy           = 1'b1;
            mem_req        = cl_mem_req[grant_id_q];
            mem_start_addr = cl_mem_start_addr[grant_id_q];
            mem_size_bytes = cl_mem_size_bytes[grant_id_q];
            mem_data       = cl_mem_data[grant_id_q];
            mem_last_valid = cl_mem_last_valid[grant_id_q];
            last           = cl_last[grant_id_q];
            // An ack arriving while the owner is abandoning does not belong to any line.
            cl_mem_ack[grant_id_q] = mem_ack && cl_mem_req[grant_id_q];
        end
    end

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;

    localparam int N    = 4;
    localparam int AW   = 19;
    localparam int LW   = 256;
    localparam int LVW  = 5;
    localparam int IDW  = 2;

    logic                     clk;
    logic                     rst_n;
    logic [N-1:0]             cl_mem_req;
    logic [N-1:0][AW-1:0]     cl_mem_start_addr;
    logic [N-1:0][AW-1:0]     cl_mem_size_bytes;
    logic [N-1:0][LW-1:0]     cl_mem_data;
    logic [N-1:0][LVW-1:0]    cl_mem_last_valid;
    logic [N-1:0]             cl_last;
    logic [N-1:0]             cl_mem_ack;
    logic                     mem_req;
    logic [AW-1:0]            mem_start_addr;
    logic [AW-1:0]            mem_size_bytes;
    logic [LW-1:0]            mem_data;
    logic [LVW-1:0]           mem_last_valid;
    logic                     last;
    logic                     mem_ack;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    int n_err = 0;
    int n_chk = 0;

    mem_write_arbiter #(
        .NUM_CLIENTS(N), .WORD_WIDTH(8), .NUM_WORDS_IN_LINE(32), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cl_mem_req(cl_mem_req), .cl_mem_start_addr(cl_mem_start_addr),
        .cl_mem_size_bytes(cl_mem_size_bytes), .cl_mem_data(cl_mem_data),
        .cl_mem_last_valid(cl_mem_last_valid), .cl_last(cl_last),
        .cl_mem_ack(cl_mem_ack), .mem_req(mem_req), .mem_start_addr(mem_start_addr),
        .mem_size_bytes(mem_size_bytes), .mem_data(mem_data), .mem_last_valid(mem_last_valid),
        .last(last), .mem_ack(mem_ack), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cl_mem_req = '0;
        cl_last    = '0;
        mem_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_client(input int id, input int addr, input int size, input int lv);
        cl_mem_req[id]        = 1'b1;
        cl_mem_start_addr[id] = AW'(addr);
        cl_mem_size_bytes[id] = AW'(size);
        cl_mem_last_valid[id] = LVW'(lv);
        cl_mem_data[id]       = {8{$urandom()}};
        cl_last[id]           = 1'b0;
    endtask

    // Returns the first granted client (or -1) and how many idle cycles preceded it.
    task automatic wait_grant(output int id, output int idle_n);
        bit found;
        found  = 1'b0;
        id     = -1;
        idle_n = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (busy) begin
                found = 1'b1;
                id    = int'(grant_id);
            end else begin
                idle_n++;
            end
        end
    endtask

    // Acks `lines` lines of client id; reports the OR of all acks seen and how
    // many lines reached client id with matching data.
    task automatic serve(input int id, input int lines, input bit final_line,
                         output logic [N-1:0] ack_or, output int got);
        ack_or = '0;
        got    = 0;
        for (int k = 0; k < lines; k++) begin
            cl_last[id]     = final_line && (k == lines - 1);
            cl_mem_data[id] = {8{$urandom()}};
            mem_ack         = 1'b1;
            #2;
            ack_or = ack_or | cl_mem_ack;
            if (cl_mem_ack[id] && mem_data == cl_mem_data[id] && last == cl_last[id]) got++;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        if (final_line) begin
            cl_mem_req[id] = 1'b0;
            cl_last[id]    = 1'b0;
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n      = 1'b0;
        cl_mem_req = '1;
        cl_last    = '1;
        mem_ack    = 1'b1;
        for (int i = 0; i < N; i++) set_client(i, 'h55, 'h40, 3);
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_chk++; if (grant_id !== '0) begin n_err++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        n_chk++; if (cl_mem_ack !== '0) begin n_err++; $display("FAIL reset_cl_mem_ack got=%b exp=0", cl_mem_ack); end
        n_chk++; if (mem_data !== '0 || mem_start_addr !== '0 || mem_size_bytes !== '0 || last !== 1'b0)
            begin n_err++; $display("FAIL reset_mem_port addr=%h size=%h last=%b exp all 0", mem_start_addr, mem_size_bytes, last); end
        tick();
        cl_mem_req = '0;
        cl_last    = '0;
        mem_ack    = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_client();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        tick();
        set_client(2, 'h100, 96, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 2) begin n_err++; $display("FAIL single_grant got=%0d exp=2", id); end
        n_chk++; if (idle_n != 1) begin n_err++; $display("FAIL single_latency got=%0d exp=1", idle_n); end
        n_chk++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL single_mem_req got=%b exp=1", mem_req); end
        n_chk++; if (mem_start_addr !== AW'('h100) || mem_size_bytes !== AW'(96) || mem_last_valid !== LVW'(31))
            begin n_err++; $display("FAIL single_bundle addr=%h size=%0d lv=%0d exp 100/96/31", mem_start_addr, mem_size_bytes, mem_last_valid); end
        n_chk++; if (cl_mem_ack !== '0) begin n_err++; $display("FAIL single_no_ack got=%b exp=0000", cl_mem_ack); end
        serve(2, 3, 1'b1, ack_or, got);
        n_chk++; if (ack_or !== 4'b0100) begin n_err++; $display("FAIL single_ack_route got=%b exp=0100", ack_or); end
        n_chk++; if (got != 3) begin n_err++; $display("FAIL single_lines got=%0d exp=3", got); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL single_idle busy=%b mem_req=%b exp 0/0", busy, mem_req); end
    endtask

    // rr_ptr is 3 after the previous test, so client 3 beats client 1.
    task automatic test_rr_after_single();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        tick();
        set_client(1, 'h10, 32, 31);
        set_client(3, 'h20, 32, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 3) begin n_err++; $display("FAIL rr_first got=%0d exp=3", id); end
        serve(3, 1, 1'b1, ack_or, got);
        n_chk++; if (ack_or !== 4'b1000) begin n_err++; $display("FAIL rr_ack3 got=%b exp=1000", ack_or); end
        wait_grant(id, idle_n);
        n_chk++; if (id != 1 || idle_n != 1) begin n_err++; $display("FAIL rr_second got=%0d idle=%0d exp=1 idle=1", id, idle_n); end
        serve(1, 2, 1'b1, ack_or, got);
        n_chk++; if (ack_or !== 4'b0010 || got != 2) begin n_err++; $display("FAIL rr_ack1 got=%b/%0d exp=0010/2", ack_or, got); end
    endtask

    task automatic test_all_four();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        do_reset();
        for (int i = 0; i < N; i++) set_client(i, 'h200 + i * 'h40, 32, 31);
        for (int i = 0; i < N; i++) begin
            wait_grant(id, idle_n);
            n_chk++; if (id != i || idle_n != 1) begin n_err++; $display("FAIL all4_order[%0d] got=%0d idle=%0d exp=%0d idle=1", i, id, idle_n, i); end
            serve(i, 1, 1'b1, ack_or, got);
            n_chk++; if (ack_or !== (N'(1) << i) || got != 1) begin n_err++; $display("FAIL all4_ack[%0d] got=%b/%0d", i, ack_or, got); end
        end
    endtask

    task automatic test_wrap();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        do_reset();
        set_client(3, 'h300, 64, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 3) begin n_err++; $display("FAIL wrap_first got=%0d exp=3", id); end
        set_client(0, 'h400, 32, 31);
        serve(3, 2, 1'b1, ack_or, got);
        set_client(3, 'h380, 32, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 0 || idle_n != 1) begin n_err++; $display("FAIL wrap_next got=%0d idle=%0d exp=0 idle=1", id, idle_n); end
        serve(0, 1, 1'b1, ack_or, got);
        n_chk++; if (ack_or !== 4'b0001) begin n_err++; $display("FAIL wrap_ack0 got=%b exp=0001", ack_or); end
        wait_grant(id, idle_n);
        n_chk++; if (id != 3) begin n_err++; $display("FAIL wrap_third got=%0d exp=3", id); end
        serve(3, 1, 1'b1, ack_or, got);
    endtask

    task automatic test_abort();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        do_reset();
        set_client(1, 'h500, 128, 31);
        set_client(2, 'h600, 32, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 1) begin n_err++; $display("FAIL abort_first got=%0d exp=1", id); end
        serve(1, 1, 1'b0, ack_or, got);
        cl_mem_req[1] = 1'b0;
        mem_ack       = 1'b1;
        #2;
        n_chk++; if (cl_mem_ack !== '0 || mem_req !== 1'b0) begin n_err++; $display("FAIL abort_no_ack ack=%b mem_req=%b exp 0000/0", cl_mem_ack, mem_req); end
        tick();
        mem_ack = 1'b0;
        wait_grant(id, idle_n);
        n_chk++; if (id != 2 || idle_n != 1) begin n_err++; $display("FAIL abort_next got=%0d idle=%0d exp=2 idle=1", id, idle_n); end
        serve(2, 1, 1'b1, ack_or, got);
        n_chk++; if (ack_or !== 4'b0100 || got != 1) begin n_err++; $display("FAIL abort_ack2 got=%b/%0d exp=0100/1", ack_or, got); end
    endtask

    task automatic test_reset_mid();
        int id, idle_n, got;
        logic [N-1:0] ack_or;
        do_reset();
        set_client(2, 'h700, 160, 31);
        wait_grant(id, idle_n);
        n_chk++; if (id != 2) begin n_err++; $display("FAIL rstmid_first got=%0d exp=2", id); end
        set_client(0, 'h800, 32, 31);
        serve(2, 1, 1'b0, ack_or, got);
        mem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || mem_req !== 1'b0 || cl_mem_ack !== '0)
            begin n_err++; $display("FAIL rstmid_drop busy=%b mem_req=%b ack=%b exp 0", busy, mem_req, cl_mem_ack); end
        n_chk++; if (mem_data !== '0 || grant_id !== '0) begin n_err++; $display("FAIL rstmid_port grant_id=%0d exp=0, data zero", grant_id); end
        mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_grant(id, idle_n);
        n_chk++; if (id != 0 || idle_n != 1) begin n_err++; $display("FAIL rstmid_next got=%0d idle=%0d exp=0 idle=1", id, idle_n); end
        serve(0, 1, 1'b1, ack_or, got);
        wait_grant(id, idle_n);
        n_chk++; if (id != 2) begin n_err++; $display("FAIL rstmid_rereq got=%0d exp=2", id); end
        serve(2, 1, 1'b1, ack_or, got);
    endtask

    task automatic test_idle_ack();
        tick();
        cl_mem_req = '0;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1;
            #2;
            n_chk++; if (cl_mem_ack !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_ack[%0d] ack=%b busy=%b exp 0000/0", k, cl_mem_ack, busy); end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // Random clients against a transaction-level model: each client owns a
    // count of remaining lines, the model tracks owner and round-robin pointer.
    task automatic test_random();
        bit           m_busy;
        int           m_gid, m_rr;
        int           rem[N];
        logic [N-1:0] exp_ack;
        bit           exp_req;
        do_reset();
        m_busy = 1'b0;
        m_gid  = 0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && cl_mem_req[i]) begin
                    cl_mem_req[i] = 1'b0;
                    cl_last[i]    = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!cl_mem_req[i] && $urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 4);
                    set_client(i, int'($urandom_range(0, 'h7ffff)), rem[i] * 32, int'($urandom_range(0, 31)));
                    cl_last[i] = (rem[i] == 1);
                end
            end
            if (m_busy && cl_mem_req[m_gid] && $urandom_range(0, 39) == 0) begin
                cl_mem_req[m_gid] = 1'b0;
                cl_last[m_gid]    = 1'b0;
                rem[m_gid]        = 0;
            end
            mem_ack = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_req = m_busy && cl_mem_req[m_gid];
            exp_ack = '0;
            if (exp_req && mem_ack) exp_ack[m_gid] = 1'b1;
            n_chk++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
            n_chk++; if (cl_mem_ack !== exp_ack) begin n_err++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, cl_mem_ack, exp_ack); end
            n_chk++; if (mem_req !== exp_req) begin n_err++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req); end
            if (m_busy) begin
                n_chk++; if (int'(grant_id) != m_gid) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_gid); end
            end
            if (exp_req) begin
                n_chk++;
                if (mem_data !== cl_mem_data[m_gid] || mem_start_addr !== cl_mem_start_addr[m_gid] ||
                    mem_size_bytes !== cl_mem_size_bytes[m_gid] || mem_last_valid !== cl_mem_last_valid[m_gid] ||
                    last !== cl_last[m_gid])
                    begin n_err++; $display("FAIL rnd_bundle cyc=%0d client=%0d addr=%h exp=%h", cyc, m_gid, mem_start_addr, cl_mem_start_addr[m_gid]); end
            end else if (!m_busy) begin
                n_chk++; if (mem_data !== '0 || mem_start_addr !== '0 || last !== 1'b0)
                    begin n_err++; $display("FAIL rnd_idle_port cyc=%0d addr=%h exp=0", cyc, mem_start_addr); end
            end
            @(posedge clk);
            if (m_busy) begin
                if (!cl_mem_req[m_gid]) begin
                    m_busy = 1'b0;
                    m_rr   = (m_gid + 1) % N;
                end else if (mem_ack) begin
                    rem[m_gid]--;
                    if (rem[m_gid] == 0) begin
                        m_busy = 1'b0;
                        m_rr   = (m_gid + 1) % N;
                    end
                end
            end else if (cl_mem_req != '0) begin
                m_busy = 1'b1;
                m_gid  = pick(cl_mem_req, m_rr);
            end
            #1;
            if (exp_ack != '0 && rem[m_gid] > 0) begin
                cl_last[m_gid]     = (rem[m_gid] == 1);
                cl_mem_data[m_gid] = {8{$urandom()}};
            end
        end
        cl_mem_req = '0;
        mem_ack    = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        cl_mem_req        = '0;
        cl_mem_start_addr = '0;
        cl_mem_size_bytes = '0;
        cl_mem_data       = '0;
        cl_mem_last_valid = '0;
        cl_last           = '0;
        mem_ack           = 1'b0;
        test_reset();
        test_single_client();
        test_rr_after_single();
        test_all_four();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_idle_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
